// File: rtl/rgmii_rx.sv
// rgmii_rx: RGMII receive front end for fixed-size payload frames.
//
// Turns the DDR RGMII nibble stream into one byte per clk125 cycle and parses
// the frame that follows the SFD: dst MAC (unicast MAC or broadcast), src MAC
// (ignored), EtherType, 16-bit sequence field, 1024 payload bytes and the FCS.
// Payload bytes go to a double-buffered memory. The bank being filled is
// always ~idx. Only a fully checked frame flips idx, so the bank named by idx
// always holds the last good payload.
//
// Ports
//   clk125      in   125 MHz clock (posedge and negedge both used for capture)
//   rst_n       in   asynchronous active-low reset
//   rxctl       in   RGMII control: DV at posedge, DV^ER at negedge
//   rxd[3:0]    in   RGMII data: bits[3:0] at posedge, bits[7:4] at negedge
//   wrad[10:0]  out  payload write address {bank, offset[9:0]}
//   wrdata[7:0] out  payload write data
//   we          out  write strobe. Each high cycle carries exactly one byte at
//                    wrad/wrdata. There is no back-pressure.
//   idx         out  bank holding the last good payload
//   seq[15:0]   out  sequence field of the last good frame
//   frm_ok      out  one-cycle pulse per accepted frame
//   frm_bad     out  one-cycle pulse per rejected frame
//   dbg_state_o out  current parser state
`timescale 1ns/1ps
module rgmii_rx #(
    parameter logic [47:0] MAC   = 48'h0088dab8bf08,
    parameter logic [15:0] ETYPE = 16'h1919
) (
    input  logic        clk125,
    input  logic        rst_n,
    input  logic        rxctl,
    input  logic [3:0]  rxd,
    output logic [10:0] wrad,
    output logic [7:0]  wrdata,
    output logic        we,
    output logic        idx,
    output logic [15:0] seq,
    output logic        frm_ok,
    output logic        frm_bad,
    output logic [2:0]  dbg_state_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, PRE, HDR, PAY, FCS, DROP} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_FRAME   = 11'd1044;
    localparam logic [10:0] LAST_PAY    = 11'd1039;

    // Reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // ---------------- DDR capture ----------------
    logic [3:0] lo_q, hi_q;
    logic       dv_pos_q, ctl_neg_q;
    logic [7:0] byte_q;
    logic       bdv_q, ber_q;
    // fill_q[1] marks that byte_q/bdv_q come from real samples rather than
    // reset values. Without it, a reset released mid-frame would see a fake
    // dv=0 and re-arm on the tail of the frame.
    logic [1:0] fill_q;

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            lo_q     <= 4'h0;
            dv_pos_q <= 1'b0;
            byte_q   <= 8'h00;
            bdv_q    <= 1'b0;
            ber_q    <= 1'b0;
            fill_q   <= 2'b00;
        end else begin
            lo_q     <= rxd;
            dv_pos_q <= rxctl;
            byte_q   <= {hi_q, lo_q};
            bdv_q    <= dv_pos_q;
            ber_q    <= dv_pos_q ^ ctl_neg_q;
            fill_q   <= {fill_q[0], 1'b1};
        end
    end

    always_ff @(negedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= 4'h0;
            ctl_neg_q <= 1'b0;
        end else begin
            hi_q      <= rxd;
            ctl_neg_q <= rxctl;
        end
    end

    // ---------------- parser ----------------
    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;          // bytes received since the SFD
    logic [9:0]  off_q, off_d;          // payload write offset
    logic [31:0] crc_q, crc_d;
    logic        mac_ok_q, mac_ok_d;    // dst bytes so far equal MAC
    logic        bcast_q, bcast_d;      // dst bytes so far all 8'hFF
    logic [15:0] seq_tmp_q, seq_tmp_d;
    logic        quiet_q, quiet_d;      // drop began before the SFD: no frm_bad
    logic        armed_q, armed_d;      // a real dv=0 has been seen since reset
    logic        we_q, we_d;
    logic [10:0] wrad_q, wrad_d;
    logic [7:0]  wrdata_q, wrdata_d;
    logic        idx_q, idx_d;
    logic [15:0] seq_q, seq_d;
    logic        frm_ok_q, frm_ok_d;
    logic        frm_bad_q, frm_bad_d;

    logic [10:0] cnt_inc;
    logic [9:0]  off_inc;
    logic [31:0] crc_nxt;
    logic [7:0]  mac_byte;

    assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign off_inc = (off_q == 10'h3FF) ? off_q : off_q + 10'd1;
    assign crc_nxt = crc32_byte(crc_q, byte_q);

    // MAC[7:0] is the first dst byte on the wire.
    always_comb begin
        mac_byte = 8'h00;
        case (cnt_q[2:0])
            3'd0:    mac_byte = MAC[7:0];
            3'd1:    mac_byte = MAC[15:8];
            3'd2:    mac_byte = MAC[23:16];
            3'd3:    mac_byte = MAC[31:24];
            3'd4:    mac_byte = MAC[39:32];
            3'd5:    mac_byte = MAC[47:40];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        crc_d     = crc_q;
        mac_ok_d  = mac_ok_q;
        bcast_d   = bcast_q;
        seq_tmp_d = seq_tmp_q;
        quiet_d   = quiet_q;
        armed_d   = armed_q | (fill_q[1] & ~bdv_q);
        we_d      = 1'b0;
        wrad_d    = wrad_q;
        wrdata_d  = wrdata_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        frm_ok_d  = 1'b0;
        frm_bad_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ber_q) begin
                    state_d = DROP;
                    quiet_d = 1'b1;
                end else if (bdv_q && armed_q) begin
                    quiet_d = 1'b1;
                    state_d = (byte_q == 8'h55) ? PRE : DROP;
                end
            end
            PRE: begin
                if (!bdv_q) begin
                    state_d = IDLE;
                end else if (ber_q) begin
                    state_d = DROP;
                    quiet_d = 1'b1;
                end else if (byte_q == 8'hD5) begin
                    state_d  = HDR;
                    cnt_d    = 11'd0;
                    off_d    = 10'd0;
                    crc_d    = CRC_INIT;
                    mac_ok_d = 1'b1;
                    bcast_d  = 1'b1;
                end else if (byte_q != 8'h55) begin
                    state_d = DROP;
                    quiet_d = 1'b1;
                end
            end
            HDR: begin
                if (!bdv_q) begin
                    state_d   = IDLE;
                    frm_bad_d = 1'b1;
                end else if (ber_q) begin
                    state_d = DROP;
                    quiet_d = 1'b0;
                end else begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_inc;
                    if (cnt_q < 11'd6) begin
                        mac_ok_d = mac_ok_q & (byte_q == mac_byte);
                        bcast_d  = bcast_q & (byte_q == 8'hFF);
                    end
                    if (cnt_q == 11'd14) seq_tmp_d[7:0]  = byte_q;
                    if (cnt_q == 11'd15) begin
                        seq_tmp_d[15:8] = byte_q;
                        state_d         = PAY;
                    end
                    if ((cnt_q == 11'd5 && !mac_ok_d && !bcast_d) ||
                        (cnt_q == 11'd12 && byte_q != ETYPE[15:8]) ||
                        (cnt_q == 11'd13 && byte_q != ETYPE[7:0])) begin
                        state_d = DROP;
                        quiet_d = 1'b0;
                    end
                end
            end
            PAY: begin
                if (!bdv_q) begin
                    state_d   = IDLE;
                    frm_bad_d = 1'b1;
                end else if (ber_q) begin
                    state_d = DROP;
                    quiet_d = 1'b0;
                end else begin
                    crc_d    = crc_nxt;
                    cnt_d    = cnt_inc;
                    off_d    = off_inc;
                    we_d     = 1'b1;
                    wrdata_d = byte_q;
                    wrad_d   = {~idx_q, off_q};
                    if (cnt_q == LAST_PAY) state_d = FCS;
                end
            end
            FCS: begin
                if (!bdv_q) begin
                    state_d = IDLE;
                    if (cnt_q == LEN_FRAME && crc_q == CRC_RESIDUE) begin
                        frm_ok_d = 1'b1;
                        idx_d    = ~idx_q;
                        seq_d    = seq_tmp_q;
                    end else begin
                        frm_bad_d = 1'b1;
                    end
                end else if (ber_q || cnt_q >= LEN_FRAME) begin
                    state_d = DROP;
                    quiet_d = 1'b0;
                end else begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_inc;
                end
            end
            DROP: begin
                if (!bdv_q) begin
                    state_d   = IDLE;
                    frm_bad_d = ~quiet_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 11'd0;
            off_q     <= 10'd0;
            crc_q     <= CRC_INIT;
            mac_ok_q  <= 1'b0;
            bcast_q   <= 1'b0;
            seq_tmp_q <= 16'h0000;
            quiet_q   <= 1'b0;
            armed_q   <= 1'b0;
            we_q      <= 1'b0;
            wrad_q    <= 11'd0;
            wrdata_q  <= 8'h00;
            idx_q     <= 1'b0;
            seq_q     <= 16'h0000;
            frm_ok_q  <= 1'b0;
            frm_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            crc_q     <= crc_d;
            mac_ok_q  <= mac_ok_d;
            bcast_q   <= bcast_d;
            seq_tmp_q <= seq_tmp_d;
            quiet_q   <= quiet_d;
            armed_q   <= armed_d;
            we_q      <= we_d;
            wrad_q    <= wrad_d;
            wrdata_q  <= wrdata_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            frm_ok_q  <= frm_ok_d;
            frm_bad_q <= frm_bad_d;
        end
    end

    assign we          = we_q;
    assign wrad        = wrad_q;
    assign wrdata      = wrdata_q;
    assign idx         = idx_q;
    assign seq         = seq_q;
    assign frm_ok      = frm_ok_q;
    assign frm_bad     = frm_bad_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_rgmii_rx.sv
`timescale 1ns/1ps
module tb_rgmii_rx;
    localparam logic [47:0] MAC       = 48'h0088dab8bf08;
    localparam logic [15:0] ETYPE     = 16'h1919;
    localparam int          FRAME_LEN = 1044;
    localparam int          PAY_LEN   = 1024;

    // ---------------- clock / reset / DUT ----------------
    logic        clk125 = 1'b0;
    logic        rst_n;
    logic        rxctl;
    logic [3:0]  rxd;
    logic [10:0] wrad;
    logic [7:0]  wrdata;
    logic        we, idx, frm_ok, frm_bad;
    logic [15:0] seq;
    logic [2:0]  dbg_state;

    rgmii_rx #(.MAC(MAC), .ETYPE(ETYPE)) dut (
        .clk125(clk125), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd),
        .wrad(wrad), .wrdata(wrdata), .we(we), .idx(idx), .seq(seq),
        .frm_ok(frm_ok), .frm_bad(frm_bad), .dbg_state_o(dbg_state)
    );

    always #4 clk125 = ~clk125;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    always @(posedge clk125) cyc <= cyc + 1;

    // ---------------- monitor (negedge sampling) ----------------
    logic [18:0] got_q[$];
    int          got_cyc_q[$];
    int          n_ok  = 0;
    int          n_bad = 0;
    always @(negedge clk125) begin
        if (we === 1'b1) begin
            got_q.push_back({wrad, wrdata});
            got_cyc_q.push_back(cyc);
        end
        if (frm_ok === 1'b1)  n_ok++;
        if (frm_bad === 1'b1) n_bad++;
    end

    // ---------------- reference model ----------------
    logic [7:0]  frm[$];      // frame bytes after the SFD
    logic [18:0] exp_q[$];    // expected {wrad, wrdata} for the current frame
    logic [18:0] cur_q[$];    // observed writes for the current frame
    bit          m_idx = 1'b0;
    logic [15:0] m_seq = 16'h0000;
    bit          exp_good;
    int          d_ok, d_bad, lat, sent_cyc, pay0_cyc;

    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ frm[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et,
                               input logic [15:0] sq, input bit rnd_pay);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[8*i +: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'h66);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        frm.push_back(sq[7:0]);
        frm.push_back(sq[15:8]);
        for (int k = 0; k < PAY_LEN; k++)
            frm.push_back(rnd_pay ? 8'($urandom_range(0, 255)) : 8'(k));
        fcs = ~crc_ref(16 + PAY_LEN);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask

    // Oldest-difference index between observed and expected writes, -1 if equal.
    function automatic int wr_first_diff();
        int n;
        n = (cur_q.size() < exp_q.size()) ? cur_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (cur_q[i] !== exp_q[i]) return i;
        if (cur_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input bit dv, input bit er);
        @(negedge clk125); #1;
        rxd   = b[3:0];
        rxctl = dv;
        @(posedge clk125); #1;
        sent_cyc = cyc;
        rxd   = b[7:4];
        rxctl = dv ^ er;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    // Sends preamble, SFD and the first n_send bytes of frm, with er on byte
    // er_at (-1 for none); fills in the model's verdict and observed results.
    task automatic run_frame(input int pre_len, input int n_send, input int er_at);
        logic [47:0] dst;
        logic [15:0] et;
        logic [31:0] fcs;
        bit          dst_ok, et_ok, fcs_ok;
        int          g0, ok0, bad0, pos;
        for (int i = 0; i < 6; i++) dst[8*i +: 8] = frm[i];
        et     = {frm[12], frm[13]};
        fcs    = {frm[1043], frm[1042], frm[1041], frm[1040]};
        fcs_ok = (fcs == ~crc_ref(16 + PAY_LEN));
        dst_ok = (dst == MAC) || (dst == 48'hFFFF_FFFF_FFFF);
        et_ok  = (et == ETYPE);
        exp_good = dst_ok && et_ok && fcs_ok && (n_send == FRAME_LEN) && (er_at < 0);
        exp_q.delete();
        if (dst_ok && et_ok)
            for (int k = 0; k < PAY_LEN; k++) begin
                pos = 16 + k;
                if (pos < n_send && (er_at < 0 || pos < er_at))
                    exp_q.push_back({~m_idx, k[9:0], frm[pos]});
            end

        g0 = got_q.size(); ok0 = n_ok; bad0 = n_bad;
        pay0_cyc = -100;
        for (int i = 0; i < pre_len; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n_send; i++) begin
            send_byte(frm[i], 1'b1, i == er_at);
            if (i == 16) pay0_cyc = sent_cyc;
        end
        send_idle(12);

        cur_q.delete();
        for (int i = g0; i < got_q.size(); i++) cur_q.push_back(got_q[i]);
        lat   = (got_q.size() > g0) ? got_cyc_q[g0] - pay0_cyc : -1;
        d_ok  = n_ok - ok0;
        d_bad = n_bad - bad0;
        if (exp_good) begin
            m_idx = ~m_idx;
            m_seq = {frm[15], frm[14]};
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; rxctl = 1'b0; rxd = 4'h0;
        repeat (3) @(posedge clk125);
        @(negedge clk125);
        n_vec++;
        if ({we, wrad, wrdata, idx, seq, frm_ok, frm_bad} !== 39'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got we=%b wrad=%h wrdata=%h idx=%b seq=%h ok=%b bad=%b, expected all 0",
                     we, wrad, wrdata, idx, seq, frm_ok, frm_bad);
        end
        rst_n = 1'b1;
        send_idle(4);
    endtask

    task automatic test_good_frame();
        int d;
        build_frame(MAC, ETYPE, 16'h0102, 1'b0);
        run_frame(7, FRAME_LEN, -1);
        n_vec++; if (d_ok !== 1) begin n_mis++; $display("FAIL good_frm_ok: got %0d pulses, expected 1", d_ok); end
        n_vec++; if (d_bad !== 0) begin n_mis++; $display("FAIL good_frm_bad: got %0d pulses, expected 0", d_bad); end
        n_vec++; if (idx !== 1'b1) begin n_mis++; $display("FAIL good_idx: got %b, expected 1", idx); end
        n_vec++; if (seq !== 16'h0102) begin n_mis++; $display("FAIL good_seq: got %h, expected 0102", seq); end
        n_vec++; if (cur_q.size() !== 1024) begin n_mis++; $display("FAIL good_nwrites: got %0d, expected 1024", cur_q.size()); end
        if (cur_q.size() == 1024) begin
            n_vec++; if (cur_q[0][18:8] !== 11'h400) begin n_mis++; $display("FAIL good_first_addr: got %h, expected 400", cur_q[0][18:8]); end
            n_vec++; if (cur_q[1023][18:8] !== 11'h7FF) begin n_mis++; $display("FAIL good_last_addr: got %h, expected 7ff", cur_q[1023][18:8]); end
        end
        d = wr_first_diff();
        n_vec++; if (d !== -1) begin n_mis++; $display("FAIL good_writes: diverge at write %0d (got %0d writes, expected %0d)", d, cur_q.size(), exp_q.size()); end
        n_vec++; if (lat !== 2) begin n_mis++; $display("FAIL good_latency: got %0d cycles, expected 2", lat); end
    endtask

    task automatic test_back_to_back();
        int d;
        build_frame(MAC, ETYPE, 16'($urandom_range(0, 65535)), 1'b1);
        run_frame(7, FRAME_LEN, -1);
        n_vec++; if (d_ok !== 1) begin n_mis++; $display("FAIL b2b_frm_ok: got %0d pulses, expected 1", d_ok); end
        n_vec++; if (idx !== 1'b0) begin n_mis++; $display("FAIL b2b_idx: got %b, expected 0", idx); end
        n_vec++; if (seq !== m_seq) begin n_mis++; $display("FAIL b2b_seq: got %h, expected %h", seq, m_seq); end
        if (cur_q.size() == 1024) begin
            n_vec++; if (cur_q[0][18:8] !== 11'h000) begin n_mis++; $display("FAIL b2b_first_addr: got %h, expected 000", cur_q[0][18:8]); end
            n_vec++; if (cur_q[1023][18:8] !== 11'h3FF) begin n_mis++; $display("FAIL b2b_last_addr: got %h, expected 3ff", cur_q[1023][18:8]); end
        end
        d = wr_first_diff();
        n_vec++; if (d !== -1) begin n_mis++; $display("FAIL b2b_writes: diverge at write %0d (got %0d writes, expected %0d)", d, cur_q.size(), exp_q.size()); end
    endtask

    // Frame expected to be rejected: one frm_bad, no frm_ok, idx/seq held.
    task automatic test_bad_crc();
        int d, p;
        logic [7:0] m;
        build_frame(MAC, ETYPE, 16'hA5A5, 1'b1);
        p = 16 + $urandom_range(0, PAY_LEN - 1);
        m = 8'h01 << $urandom_range(0, 7);
        frm[p] = frm[p] ^ m;
        run_frame(7, FRAME_LEN, -1);
        n_vec++; if (d_bad !== 1 || d_ok !== 0) begin n_mis++; $display("FAIL crc_pulses: got ok=%0d bad=%0d, expected ok=0 bad=1", d_ok, d_bad); end
        n_vec++; if (idx !== m_idx || seq !== m_seq) begin n_mis++; $display("FAIL crc_state: got idx=%b seq=%h, expected idx=%b seq=%h", idx, seq, m_idx, m_seq); end
        d = wr_first_diff();
        n_vec++; if (d !== -1) begin n_mis++; $display("FAIL crc_writes: diverge at write %0d (got %0d writes, expected %0d)", d, cur_q.size(), exp_q.size()); end
    endtask

    task automatic test_mac_mismatch();
        build_frame(48'h0188dab8bf08, ETYPE, 16'h1111, 1'b1);
        run_frame(7, FRAME_LEN, -1);
        n_vec++; if (cur_q.size() !== 0) begin n_mis++; $display("FAIL mac_writes: got %0d writes, expected 0", cur_q.size()); end
        n_vec++; if (d_bad !== 1 || d_ok !== 0) begin n_mis++; $display("FAIL mac_pulses: got ok=%0d bad=%0d, expected ok=0 bad=1", d_ok, d_bad); end
        n_vec++; if (idx !== m_idx) begin n_mis++; $display("FAIL mac_idx: got %b, expected %b", idx, m_idx); end
    endtask

    task automatic test_etype();
        build_frame(MAC, 16'h0800, 16'h2222, 1'b1);
        run_frame(3, FRAME_LEN, -1);
        n_vec++; if (cur_q.size() !== 0) begin n_mis++; $display("FAIL etype_writes: got %0d writes, expected 0", cur_q.size()); end
        n_vec++; if (d_bad !== 1 || d_ok !== 0) begin n_mis++; $display("FAIL etype_pulses: got ok=%0d bad=%0d, expected ok=0 bad=1", d_ok, d_bad); end
    endtask

    task automatic test_truncated();
        int d;
        build_frame(MAC, ETYPE, 16'h3333, 1'b1);
        run_frame(7, 16 + 500, -1);
        n_vec++; if (d_bad !== 1 || d_ok !== 0) begin n_mis++; $display("FAIL trunc_pulses: got ok=%0d bad=%0d, expected ok=0 bad=1", d_ok, d_bad); end
        n_vec++; if (idx !== m_idx) begin n_mis++; $display("FAIL trunc_idx: got %b, expected %b", idx, m_idx); end
        d = wr_first_diff();
        n_vec++; if (d !== -1) begin n_mis++; $display("FAIL trunc_writes: diverge at write %0d (got %0d writes, expected %0d)", d, cur_q.size(), exp_q.size()); end
    endtask

    task automatic test_er();
        int d;
        build_frame(MAC, ETYPE, 16'h4444, 1'b1);
        run_frame(7, FRAME_LEN, 16 + 10);
        n_vec++; if (d_bad !== 1 || d_ok !== 0) begin n_mis++; $display("FAIL er_pulses: got ok=%0d bad=%0d, expected ok=0 bad=1", d_ok, d_bad); end
        n_vec++; if (idx !== m_idx || seq !== m_seq) begin n_mis++; $display("FAIL er_state: got idx=%b seq=%h, expected idx=%b seq=%h", idx, seq, m_idx, m_seq); end
        d = wr_first_diff();
        n_vec++; if (d !== -1) begin n_mis++; $display("FAIL er_writes: diverge at write %0d (got %0d writes, expected %0d)", d, cur_q.size(), exp_q.size()); end
    endtask

    task automatic test_oversize();
        build_frame(MAC, ETYPE, 16'h5555, 1'b1);
        frm.push_back(8'h3C);
        run_frame(7, FRAME_LEN + 1, -1);
        n_vec++; if (d_bad !== 1 || d_ok !== 0) begin n_mis++; $display("FAIL over_pulses: got ok=%0d bad=%0d, expected ok=0 bad=1", d_ok, d_bad); end
        n_vec++; if (idx !== m_idx) begin n_mis++; $display("FAIL over_idx: got %b, expected %b", idx, m_idx); end
    endtask

    task automatic test_broadcast_short_pre();
        build_frame(48'hFFFF_FFFF_FFFF, ETYPE, 16'h6789, 1'b1);
        run_frame(1, FRAME_LEN, -1);
        n_vec++; if (d_ok !== 1 || d_bad !== 0) begin n_mis++; $display("FAIL bcast_pulses: got ok=%0d bad=%0d, expected ok=1 bad=0", d_ok, d_bad); end
        n_vec++; if (idx !== m_idx || seq !== 16'h6789) begin n_mis++; $display("FAIL bcast_state: got idx=%b seq=%h, expected idx=%b seq=6789", idx, seq, m_idx); end
    endtask

    task automatic test_random();
        int kind, d, n_send, p;
        logic [7:0] m;
        for (int t = 0; t < 6; t++) begin
            kind   = $urandom_range(0, 3);
            n_send = FRAME_LEN;
            build_frame(kind == 2 ? 48'hFFFF_FFFF_FFFF : MAC, ETYPE, 16'($urandom_range(0, 65535)), 1'b1);
            if (kind == 1) begin
                p = 16 + $urandom_range(0, PAY_LEN + 3);
                m = 8'h01 << $urandom_range(0, 7);
                frm[p] = frm[p] ^ m;
            end
            if (kind == 3) n_send = 16 + $urandom_range(1, PAY_LEN - 1);
            run_frame($urandom_range(1, 7), n_send, -1);
            n_vec++; if (d_ok !== (exp_good ? 1 : 0) || d_bad !== (exp_good ? 0 : 1)) begin
                n_mis++; $display("FAIL rnd%0d_pulses: got ok=%0d bad=%0d, expected good=%0d", t, d_ok, d_bad, exp_good);
            end
            n_vec++; if (idx !== m_idx || seq !== m_seq) begin
                n_mis++; $display("FAIL rnd%0d_state: got idx=%b seq=%h, expected idx=%b seq=%h", t, idx, seq, m_idx, m_seq);
            end
            d = wr_first_diff();
            n_vec++; if (d !== -1) begin
                n_mis++; $display("FAIL rnd%0d_writes: diverge at write %0d (got %0d, expected %0d)", t, d, cur_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int g0, ok0, bad0;
        build_frame(MAC, ETYPE, 16'hBEEF, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 16 + 300; i++) send_byte(frm[i], 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({we, wrad, wrdata, idx, seq, frm_ok, frm_bad} !== 39'd0) begin
            n_mis++;
            $display("FAIL midrst_outputs: got we=%b wrad=%h wrdata=%h idx=%b seq=%h ok=%b bad=%b, expected all 0",
                     we, wrad, wrdata, idx, seq, frm_ok, frm_bad);
        end
        for (int i = 16 + 300; i < 16 + 310; i++) send_byte(frm[i], 1'b1, 1'b0);
        rst_n = 1'b1;
        m_idx = 1'b0;
        m_seq = 16'h0000;
        g0 = got_q.size(); ok0 = n_ok; bad0 = n_bad;
        for (int i = 16 + 310; i < FRAME_LEN; i++) send_byte(frm[i], 1'b1, 1'b0);
        send_idle(12);
        n_vec++; if (got_q.size() - g0 !== 0) begin n_mis++; $display("FAIL midrst_writes: got %0d writes, expected 0", got_q.size() - g0); end
        n_vec++; if (n_ok - ok0 !== 0 || n_bad - bad0 !== 0) begin
            n_mis++; $display("FAIL midrst_pulses: got ok=%0d bad=%0d, expected 0 0", n_ok - ok0, n_bad - bad0);
        end
        n_vec++; if (idx !== 1'b0) begin n_mis++; $display("FAIL midrst_idx: got %b, expected 0", idx); end

        build_frame(MAC, ETYPE, 16'h0F0F, 1'b1);
        run_frame(7, FRAME_LEN, -1);
        n_vec++; if (d_ok !== 1) begin n_mis++; $display("FAIL midrst_next_ok: got %0d pulses, expected 1", d_ok); end
        n_vec++; if (idx !== 1'b1 || seq !== 16'h0F0F) begin n_mis++; $display("FAIL midrst_next_state: got idx=%b seq=%h, expected 1 0f0f", idx, seq); end
        n_vec++; if (wr_first_diff() !== -1) begin n_mis++; $display("FAIL midrst_next_writes: got %0d writes, expected %0d", cur_q.size(), exp_q.size()); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_bad_crc();
        test_mac_mismatch();
        test_etype();
        test_truncated();
        test_er();
        test_oversize();
        test_broadcast_short_pre();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
